// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter and write sequencer for a shared bank of gated D latches.
// Each grant captures the owner's data, strobes the bank, verifies readback and retries on mismatch.
module latch_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         err,
    output logic [WIDTH-1:0]        latch_d,
    output logic                    latch_en,
    input  logic [WIDTH-1:0]        latch_q,
    output logic                    busy,
    output logic [2:0]              owner
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, CAPTURE, STROBE, CHECK} state_t;

    state_t              r_state;
    logic [2:0]          r_owner;
    logic [2:0]          r_rr_ptr;
    logic [RW-1:0]       r_retry;
    logic [WIDTH-1:0]    r_latch_d;
    logic                r_latch_en;
    logic [NREQ-1:0]     r_ack;
    logic [NREQ-1:0]     r_err;
    logic                r_match;

    logic                w_found;
    logic [2:0]          w_grant;
    logic [2:0]          w_cand;
    logic [WIDTH-1:0]    w_slice;
    logic [NREQ-1:0]     w_onehot;
    logic [2:0]          w_next_ptr;
    logic                w_match;

    // Search rr_ptr, rr_ptr+1, ... mod NREQ; candidate index is formed without a wide modulo.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_found = 1'b0;
        w_grant = 3'd0;
        w_cand  = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_rr_ptr >= 3'(NREQ - k))
                w_cand = r_rr_ptr - 3'(NREQ - k);
            else
                w_cand = r_rr_ptr + 3'(k);
            if (!w_found && (|(req & (NREQ'(1) << w_cand)))) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    always_comb begin
        w_slice = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == 3'(i))
                w_slice = wdata[i*WIDTH +: WIDTH];
        end
    end

    assign w_onehot   = NREQ'(1) << r_owner;
    assign w_next_ptr = (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;
    // Readback is judged while the bank is still transparent, so ack/err can be registered into CHECK.
    assign w_match    = (latch_q == r_latch_d);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 3'd0;
            r_rr_ptr   <= 3'd0;
            r_retry    <= '0;
            r_latch_d  <= '0;
            r_latch_en <= 1'b0;
            r_ack      <= '0;
            r_err      <= '0;
            r_match    <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_err      <= '0;
            r_latch_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner <= w_grant;
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_latch_d  <= w_slice;
                    r_retry    <= '0;
                    r_latch_en <= 1'b1;
                    r_state    <= STROBE;
                end
                STROBE: begin
                    r_match <= w_match;
                    if (w_match)
                        r_ack <= w_onehot;
                    else if (r_retry == MAX_R)
                        r_err <= w_onehot;
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (r_match || (r_retry == MAX_R)) begin
                        r_rr_ptr <= w_next_ptr;
                        r_owner  <= 3'd0;
                        r_state  <= IDLE;
                    end else begin
                        r_retry    <= r_retry + RW'(1);
                        r_latch_en <= 1'b1;
                        r_state    <= STROBE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign latch_d  = r_latch_d;
    assign latch_en = r_latch_en;
    assign owner    = r_owner;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter with a behavioural latch bank that can hold a stuck bit or a one-shot flip.
module tb_latch_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [7:0]  latch_d;
    logic        latch_en;
    logic [7:0]  latch_q;
    logic        busy;
    logic [2:0]  owner;

    logic [7:0]  bank;
    logic [7:0]  stuck;
    logic [7:0]  flip;

    int tests = 0;
    int fails = 0;
    int pulses;

    latch_write_arbiter #(.NREQ(4), .WIDTH(8), .MAX_RETRY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .latch_d  (latch_d),
        .latch_en (latch_en),
        .latch_q  (latch_q),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    // Gated D latch bank; stuck clears bits on readback, flip inverts them.
    always_latch begin
        if (latch_en) bank <= latch_d;
    end
    assign latch_q = (bank & ~stuck) ^ flip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; wdata = 32'h0; stuck = 8'h00; flip = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_en", 32'(latch_en), 32'h0);
        check("rst_d", 32'(latch_d), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        rst = 1'b0;

        // Single request from requester 1
        wdata[15:8] = 8'hA5; req = 4'b0010;
        @(negedge clk);
        check("single_busy_c1", 32'(busy), 32'h1);
        check("single_owner_c1", 32'(owner), 32'h1);
        check("single_en_c1", 32'(latch_en), 32'h0);
        @(negedge clk);
        check("single_en_c2", 32'(latch_en), 32'h1);
        check("single_d_c2", 32'(latch_d), 32'hA5);
        check("single_ack_c2", 32'(ack), 32'h0);
        @(negedge clk);
        check("single_ack_c3", 32'(ack), 32'h2);
        check("single_err_c3", 32'(err), 32'h0);
        check("single_en_c3", 32'(latch_en), 32'h0);
        req = 4'b0;
        @(negedge clk);
        check("single_ack_c4", 32'(ack), 32'h0);
        check("single_busy_c4", 32'(busy), 32'h0);
        check("single_owner_c4", 32'(owner), 32'h0);

        // Full contention from rr_ptr = 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'hF;
        for (int c = 1; c <= 19; c++) begin
            logic [3:0] exp_ack;
            logic [7:0] exp_d;
            @(negedge clk);
            exp_ack = (c % 4 == 3) ? 4'(1 << (((c - 3) / 4) % 4)) : 4'h0;
            check("contend_ack", 32'(ack), 32'(exp_ack));
            check("contend_err", 32'(err), 32'h0);
            if (c % 4 == 2) begin
                exp_d = 8'(8'h11 * (((c - 2) / 4) % 4 + 1));
                check("contend_d", 32'(latch_d), 32'(exp_d));
                check("contend_en", 32'(latch_en), 32'h1);
            end
        end
        req = 4'b0;
        @(negedge clk);

        // Stuck bit on requester 2 (rr_ptr = 1); all three attempts fail
        stuck = 8'h01; wdata[23:16] = 8'h01; req = 4'b0100;
        pulses = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (latch_en) pulses++;
            if (c == 1) check("stuck_owner", 32'(owner), 32'h2);
            check("stuck_ack", 32'(ack), 32'h0);
            check("stuck_err", 32'(err), (c == 7) ? 32'h4 : 32'h0);
        end
        check("stuck_pulses", 32'(pulses), 32'd3);
        req = 4'b0; stuck = 8'h00;
        @(negedge clk);
        check("stuck_idle", 32'(busy), 32'h0);

        // rr_ptr moved past the failed owner to 3: search 3,0,1 picks 0
        wdata[7:0] = 8'h66; wdata[15:8] = 8'h77; req = 4'b0011;
        @(negedge clk);
        check("rr_owner", 32'(owner), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rr_ack", 32'(ack), 32'h1);
        req = 4'b0;
        @(negedge clk);

        // Transient fault on requester 1 (rr_ptr = 1): first check mismatches only
        flip = 8'h01; wdata[15:8] = 8'h5A; req = 4'b0010;
        pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (latch_en) pulses++;
            check("trans_err", 32'(err), 32'h0);
            check("trans_ack", 32'(ack), (c == 5) ? 32'h2 : 32'h0);
            if (c == 3) flip = 8'h00;
        end
        check("trans_pulses", 32'(pulses), 32'd2);
        req = 4'b0;
        @(negedge clk);

        // Owner 2 drops req and changes wdata after capture (rr_ptr = 2)
        wdata[23:16] = 8'h3C; req = 4'b0100;
        @(negedge clk);
        check("midop_owner", 32'(owner), 32'h2);
        @(negedge clk);
        check("midop_d_c2", 32'(latch_d), 32'h3C);
        check("midop_en_c2", 32'(latch_en), 32'h1);
        req = 4'b0; wdata[23:16] = 8'hFF;
        @(negedge clk);
        check("midop_d_c3", 32'(latch_d), 32'h3C);
        check("midop_ack_c3", 32'(ack), 32'h4);
        @(negedge clk);
        check("midop_ack_c4", 32'(ack), 32'h0);
        check("midop_busy_c4", 32'(busy), 32'h0);

        // Reset during STROBE (rr_ptr = 3, search 3,0,1 picks 1)
        wdata[15:8] = 8'h99; req = 4'b0010;
        @(negedge clk);
        check("rstmid_owner", 32'(owner), 32'h1);
        @(negedge clk);
        check("rstmid_en_before", 32'(latch_en), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_en", 32'(latch_en), 32'h0);
        check("rstmid_ack", 32'(ack), 32'h0);
        check("rstmid_err", 32'(err), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_owner0", 32'(owner), 32'h0);
        check("rstmid_d", 32'(latch_d), 32'h0);
        @(negedge clk);
        rst = 1'b0; req = 4'b1000; wdata[31:24] = 8'hC3;
        @(negedge clk);
        check("post_rst_owner", 32'(owner), 32'h3);
        @(negedge clk);
        check("post_rst_d", 32'(latch_d), 32'hC3);
        @(negedge clk);
        check("post_rst_ack", 32'(ack), 32'h8);
        req = 4'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
